lsb_embedder: RTL

- Writes an ASCII message into the least-significant bits of image bytes held in the block RAM.
- This is the encoder for the message extractor in the display path: one message bit per image byte, MSB first, 8 consecutive bytes per character, then a NUL terminator.
- It sits between a character source (UART or a test pattern) and the BRAM port A.
- It performs a read-modify-write per byte, so only bit 0 of each image byte changes.

---
 rtl/lsb_embedder_pkg.sv | 10 +
 rtl/lsb_embedder_if.sv | 24 ++
 rtl/lsb_embedder_merge.sv | 8 +
 rtl/lsb_embedder.sv | 89 ++++++++
 4 files changed

// File: rtl/lsb_embedder_pkg.sv
// lsb_embedder_pkg: constants and FSM encoding shared by the LSB embedder and extractor.
package lsb_embedder_pkg;
  typedef enum logic [2:0] {IDLE, ACCEPT, READ, WAIT, WRITE, TERM, FINISH} state_t;
  localparam logic [7:0] TERM_CHAR = 8'h00;
  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam int BITS_PER_CHAR = 8;
  function automatic logic [7:0] sanitize(input logic [7:0] c);
    return c == TERM_CHAR ? BLANK_CHAR : c;
  endfunction
endpackage

// File: rtl/lsb_embedder_if.sv
// lsb_embedder_if: character stream, BRAM port A and status signals of the embedder.
interface lsb_embedder_if #(parameter int ADDR_W = 12) ();
  logic start;
  logic [7:0] char_data;
  logic char_valid;
  logic char_last;
  logic char_ready;
  logic bram_en;
  logic bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0] bram_din;
  logic [7:0] bram_dout;
  logic busy;
  logic done;
  logic overflow;
  modport slave (
    input start, char_data, char_valid, char_last, bram_dout,
    output char_ready, bram_en, bram_we, bram_addr, bram_din, busy, done, overflow
  );
  modport master (
    output start, char_data, char_valid, char_last, bram_dout,
    input char_ready, bram_en, bram_we, bram_addr, bram_din, busy, done, overflow
  );
endinterface

// File: rtl/lsb_embedder_merge.sv
// lsb_merge: replaces bit 0 of an image byte with a message bit.
module lsb_merge (
  input  logic [7:0] orig,
  input  logic       lsb,
  output logic [7:0] merged
);
  assign merged = (orig & 8'hFE) | {7'b0, lsb};
endmodule

// File: rtl/lsb_embedder.sv
// lsb_embedder: read-modify-write embedding of an ASCII message, MSB first, into image byte LSBs.
module lsb_embedder
  import lsb_embedder_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int START_ADDR = 0,
  parameter int MAX_CHARS = 128,
  parameter int RD_LAT = 1
) (
  input logic CLK100MHZ,
  input logic Reset,
  lsb_embedder_if.slave bus
);
  localparam int CW = $clog2(MAX_CHARS + 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [2:0] bit_cnt;
  logic [CW-1:0] char_cnt;
  logic [7:0] sh;
  logic [7:0] merged;
  logic last_f, term_f, ovf, full;
  assign full = char_cnt == CW'(MAX_CHARS - 1);
  lsb_merge u_merge (.orig(bus.bram_dout), .lsb(sh[7]), .merged(merged));
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start ? ACCEPT : IDLE;
      ACCEPT:  state_n = !bus.char_valid ? ACCEPT : full ? TERM : READ;
      READ:    state_n = RD_LAT == 2 ? WAIT : WRITE;
      WAIT:    state_n = WRITE;
      WRITE:   state_n = bit_cnt != 3'd7 ? READ : last_f ? TERM : term_f ? FINISH : ACCEPT;
      TERM:    state_n = READ;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      state <= IDLE;
      addr <= '0;
      bit_cnt <= '0;
      char_cnt <= '0;
      sh <= '0;
      last_f <= 1'b0;
      term_f <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (bus.start) begin
          addr <= ADDR_W'(START_ADDR);
          char_cnt <= '0;
          term_f <= 1'b0;
          ovf <= 1'b0;
        end
        // A full buffer still consumes the character so the source is not stalled forever.
        ACCEPT: if (bus.char_valid) begin
          if (full) ovf <= 1'b1;
          else begin
            sh <= sanitize(bus.char_data);
            last_f <= bus.char_last;
            bit_cnt <= '0;
            char_cnt <= char_cnt + 1'b1;
          end
        end
        WRITE: begin
          addr <= addr + 1'b1;
          sh <= {sh[6:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
        end
        TERM: begin
          sh <= TERM_CHAR;
          last_f <= 1'b0;
          term_f <= 1'b1;
          bit_cnt <= '0;
        end
        default: ;
      endcase
    end
  end
  assign bus.char_ready = state == ACCEPT;
  assign bus.bram_en = state inside {READ, WAIT, WRITE};
  assign bus.bram_we = state == WRITE;
  assign bus.bram_addr = addr;
  assign bus.bram_din = state == WRITE ? merged : 8'h00;
  assign bus.busy = state != IDLE;
  assign bus.done = state == FINISH;
  assign bus.overflow = ovf;
endmodule
